// File: rtl/uart_tx_yumi.sv
// uart_tx_yumi
// Byte-serial UART transmitter that drains a valid/yumi producer and shifts
// each accepted word onto tx_o, LSB first. The frame is one start bit
// (low), width_p data bits, then stop_bits_p stop bits (high).
//
// Parameters:
//   width_p        data bits per frame (5-9)
//   clks_per_bit_p clk_i cycles per bit period (>= 2)
//   stop_bits_p    number of stop bits (1 or 2)
//
// Ports:
//   clk_i    sole clock, rising edge
//   reset_i  asynchronous active-high reset
//   valid_i  producer has a word on data_i
//   data_i   word to transmit, sampled only in the yumi_o cycle
//   yumi_o   word on data_i is taken this cycle (only in IDLE, only with valid_i)
//   tx_o     registered serial line, idle high
//   busy_o   registered, high while a frame is in progress
module uart_tx_yumi #(
    parameter int width_p        = 8,
    parameter int clks_per_bit_p = 1250,
    parameter int stop_bits_p    = 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               valid_i,
    input  logic [width_p-1:0] data_i,
    output logic               yumi_o,
    output logic               tx_o,
    output logic               busy_o
);

    // The baud counter must reach the longest period, which is the stop period.
    localparam int baud_w_lp = $clog2(clks_per_bit_p * stop_bits_p);
    localparam int bit_w_lp  = $clog2(width_p + 1);

    localparam logic [baud_w_lp-1:0] bit_last_lp  = baud_w_lp'(clks_per_bit_p - 1);
    localparam logic [baud_w_lp-1:0] stop_last_lp = baud_w_lp'(clks_per_bit_p * stop_bits_p - 1);
    localparam logic [bit_w_lp-1:0]  data_last_lp = bit_w_lp'(width_p - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    state_e               state_r;
    logic [baud_w_lp-1:0] baud_cnt_r;
    logic [bit_w_lp-1:0]  bit_cnt_r;
    logic [width_p-1:0]   shift_r;
    logic                 tx_r;
    logic                 busy_r;
    logic                 yumi_s;

    // Accept a word only while idle; reset masks acceptance immediately.
    always_comb begin
        yumi_s = 1'b0;
        if ((state_r == IDLE) && valid_i && !reset_i) begin
            yumi_s = 1'b1;
        end else begin
            yumi_s = 1'b0;
        end
    end

    // Frame sequencer: state, counters, shift register and registered outputs.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r    <= IDLE;
            baud_cnt_r <= '0;
            bit_cnt_r  <= '0;
            shift_r    <= '0;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (yumi_s) begin
                        shift_r    <= data_i;
                        baud_cnt_r <= '0;
                        bit_cnt_r  <= '0;
                        tx_r       <= 1'b0;
                        busy_r     <= 1'b1;
                        state_r    <= START;
                    end
                end
                START: begin
                    if (baud_cnt_r == bit_last_lp) begin
                        baud_cnt_r <= '0;
                        tx_r       <= shift_r[0];
                        state_r    <= DATA;
                    end else begin
                        baud_cnt_r <= baud_cnt_r + baud_w_lp'(1);
                    end
                end
                DATA: begin
                    if (baud_cnt_r == bit_last_lp) begin
                        baud_cnt_r <= '0;
                        shift_r    <= {1'b0, shift_r[width_p-1:1]};
                        if (bit_cnt_r == data_last_lp) begin
                            // Last data bit done: the line goes high for the stop period.
                            bit_cnt_r <= '0;
                            tx_r      <= 1'b1;
                            state_r   <= STOP;
                        end else begin
                            // Present the next bit before the shift lands.
                            bit_cnt_r <= bit_cnt_r + bit_w_lp'(1);
                            tx_r      <= shift_r[1];
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + baud_w_lp'(1);
                    end
                end
                STOP: begin
                    if (baud_cnt_r == stop_last_lp) begin
                        baud_cnt_r <= '0;
                        busy_r     <= 1'b0;
                        state_r    <= IDLE;
                    end else begin
                        baud_cnt_r <= baud_cnt_r + baud_w_lp'(1);
                    end
                end
                default: begin
                    baud_cnt_r <= '0;
                    bit_cnt_r  <= '0;
                    tx_r       <= 1'b1;
                    busy_r     <= 1'b0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

    assign yumi_o = yumi_s;
    assign tx_o   = tx_r;
    assign busy_o = busy_r;

endmodule

// File: tb/tb_uart_tx_yumi.sv
// Testbench for uart_tx_yumi. Two instances with clks_per_bit_p=4: one with
// one stop bit, one with two. The expected line level at every cycle of a
// frame is computed from the byte and the frame layout (bit index = cycle
// offset / bit period).
module tb_uart_tx_yumi;

    localparam int CPB = 4;
    localparam int W   = 8;

    logic       clk;
    logic       reset;
    logic       valid1, valid2;
    logic [7:0] data;
    logic       yumi1, tx1, busy1;
    logic       yumi2, tx2, busy2;

    int checks = 0;
    int errors = 0;

    uart_tx_yumi #(.width_p(W), .clks_per_bit_p(CPB), .stop_bits_p(1)) dut1 (
        .clk_i(clk), .reset_i(reset), .valid_i(valid1), .data_i(data),
        .yumi_o(yumi1), .tx_o(tx1), .busy_o(busy1)
    );

    uart_tx_yumi #(.width_p(W), .clks_per_bit_p(CPB), .stop_bits_p(2)) dut2 (
        .clk_i(clk), .reset_i(reset), .valid_i(valid2), .data_i(data),
        .yumi_o(yumi2), .tx_o(tx2), .busy_o(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic obs_tx(input int which);
        return (which == 0) ? tx1 : tx2;
    endfunction
    function automatic logic obs_busy(input int which);
        return (which == 0) ? busy1 : busy2;
    endfunction
    function automatic logic obs_yumi(input int which);
        return (which == 0) ? yumi1 : yumi2;
    endfunction

    task automatic set_valid(input int which, input logic v);
        if (which == 0) valid1 = v;
        else            valid2 = v;
    endtask

    // Line level t cycles after the start bit begins.
    function automatic logic exp_tx(input logic [7:0] d, input int t);
        int idx;
        idx = t / CPB;
        if (idx == 0)      return 1'b0;
        else if (idx <= W) return d[idx-1];
        else               return 1'b1;
    endfunction

    // Offer d, check acceptance, then check every cycle of the frame and the
    // first idle cycle after it. hold keeps valid high afterwards, wig
    // scrambles data_i after acceptance, wd pulses valid mid-frame.
    task automatic run_frame(input int which, input logic [7:0] d,
                             input bit hold, input bit wig, input bit wd);
        int s;
        int total;
        s = (which == 0) ? 1 : 2;
        total = (1 + W + s) * CPB;
        data = d;
        set_valid(which, 1'b1);
        #1;
        chk("yumi_accept", {31'd0, obs_yumi(which)}, 32'd1);
        @(negedge clk);
        if (!hold) set_valid(which, 1'b0);
        for (int t = 0; t < total; t++) begin
            if (wig) data = 8'($urandom);
            if (wd && t == 10) set_valid(which, 1'b1);
            if (wd && t == 11) set_valid(which, 1'b0);
            #1;
            chk($sformatf("tx d=%0h t=%0d", d, t), {31'd0, obs_tx(which)}, {31'd0, exp_tx(d, t)});
            chk($sformatf("busy t=%0d", t), {31'd0, obs_busy(which)}, 32'd1);
            chk($sformatf("yumi_busy t=%0d", t), {31'd0, obs_yumi(which)}, 32'd0);
            @(negedge clk);
        end
        #1;
        chk("busy_end", {31'd0, obs_busy(which)}, 32'd0);
        chk("tx_end", {31'd0, obs_tx(which)}, 32'd1);
        chk("yumi_end", {31'd0, obs_yumi(which)}, {31'd0, hold});
    endtask

    initial begin
        logic [7:0] rb;
        bit         h;
        bit         wg;

        // Reset asserted between edges with valid high.
        reset  = 1'b0;
        valid1 = 1'b1;
        valid2 = 1'b0;
        data   = 8'h00;
        #2;
        reset = 1'b1;
        #1;
        chk("rst_tx1", {31'd0, tx1}, 32'd1);
        chk("rst_yumi1", {31'd0, yumi1}, 32'd0);
        chk("rst_busy1", {31'd0, busy1}, 32'd0);
        chk("rst_tx2", {31'd0, tx2}, 32'd1);
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("rst_hold_yumi1", {31'd0, yumi1}, 32'd0);
            chk("rst_hold_tx1", {31'd0, tx1}, 32'd1);
        end
        @(negedge clk);
        reset  = 1'b0;
        valid1 = 1'b0;

        // Single word, one-cycle valid pulse.
        run_frame(0, 8'h55, 1'b0, 1'b0, 1'b0);

        // Back-to-back from a two-entry FIFO with valid held.
        begin
            logic [7:0] fifo [$];
            fifo.push_back(8'hA5);
            fifo.push_back(8'h3C);
            while (fifo.size() > 0) begin
                rb = fifo.pop_front();
                run_frame(0, rb, (fifo.size() > 0), 1'b0, 1'b0);
            end
        end

        // Data scrambled after acceptance, valid pulsed while busy.
        rb = 8'($urandom);
        run_frame(0, rb, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            chk("no_extra_tx", {31'd0, tx1}, 32'd1);
            chk("no_extra_busy", {31'd0, busy1}, 32'd0);
        end

        // Two stop bits: 36 low cycles then 8 high before the next start.
        run_frame(1, 8'h00, 1'b1, 1'b0, 1'b0);
        run_frame(1, 8'($urandom), 1'b0, 1'b0, 1'b0);

        // Reset during data bit 3 of 0xF0, then a clean 0x81 frame.
        @(negedge clk);
        data   = 8'hF0;
        valid1 = 1'b1;
        #1;
        chk("mid_yumi", {31'd0, yumi1}, 32'd1);
        @(negedge clk);
        valid1 = 1'b0;
        repeat (17) @(negedge clk);
        #1;
        chk("mid_bit3", {31'd0, tx1}, {31'd0, exp_tx(8'hF0, 17)});
        valid1 = 1'b1;
        data   = 8'h81;
        #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_tx", {31'd0, tx1}, 32'd1);
        chk("mid_rst_busy", {31'd0, busy1}, 32'd0);
        chk("mid_rst_yumi", {31'd0, yumi1}, 32'd0);
        @(negedge clk);
        #1;
        chk("mid_rst_hold_yumi", {31'd0, yumi1}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_frame(0, 8'h81, 1'b0, 1'b0, 1'b0);

        // Randomized frames with random hold and data scrambling.
        for (int i = 0; i < 6; i++) begin
            rb = 8'($urandom);
            h  = (i < 5) ? 1'($urandom) : 1'b0;
            wg = 1'($urandom);
            run_frame(0, rb, h, wg, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
